// File: rtl/fir_pkg.sv
// fir_pkg -- shared width derivations and constants for the transposed-form FIR.
//
// Contents:
//   clog2()      ceiling log2, minimum 1 (coefficient address width)
//   prod_width() signed product width, DWIDTH + CWIDTH
//   acc_width()  accumulator width, product width + clog2(NTAPS) growth bits
//   rnd_const()  half-LSB of the Q1.(CWIDTH-1) output slice, 2^(CWIDTH-2)
//   sat_max()    largest signed DWIDTH-bit output value
//   sat_min()    smallest signed DWIDTH-bit output value
// Used by fir_ttap and fir_systolic. The saturating output stage that uses
// rnd_const/sat_max/sat_min is built only when FIR_SAT_EN is defined.
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

  function automatic longint rnd_const(input int cw);
    return longint'(1) << (cw - 2);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_ttap.sv
// fir_ttap -- one transposed-form FIR tap: acc_q <= acc_in + x * coeff.
//
// Parameters:
//   DWIDTH  signed sample width
//   CWIDTH  signed coefficient width
//   AWIDTH  accumulator width (must be >= DWIDTH + CWIDTH)
// Ports:
//   clk     in   rising-edge clock
//   rstn    in   synchronous active-low reset, clears acc_q
//   en      in   load the new partial sum (an accepted sample)
//   clr     in   synchronous flush of acc_q, has priority over en
//   x       in   DWIDTH   current input sample (broadcast to all taps)
//   coeff   in   CWIDTH   active coefficient for this tap
//   acc_in  in   AWIDTH   partial sum from the next-older tap (0 for the last)
//   acc_q   out  AWIDTH   registered partial sum handed to the next-newer tap
module fir_ttap
  import fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int AWIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DWIDTH-1:0] x,
  input  logic signed [CWIDTH-1:0] coeff,
  input  logic signed [AWIDTH-1:0] acc_in,
  output logic signed [AWIDTH-1:0] acc_q
);

  localparam int P = prod_width(DWIDTH, CWIDTH);

  logic signed [P-1:0]      prod;
  logic signed [AWIDTH-1:0] sum;

  // Operands are sign-extended to the full product width first so the
  // multiply is exact; the accumulator carries clog2(NTAPS) guard bits so the
  // chain itself never overflows.
  assign prod = P'(x) * P'(coeff);
  assign sum  = acc_in + AWIDTH'(prod);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/fir_systolic.sv
// fir_systolic -- parametrised N-tap transposed-form FIR filter.
//
// y[n] = sum_k act[k] * x[n-k] over accepted samples, output scaled by taking
// the Q1.(CWIDTH-1) alignment slice. Latency one cycle, one sample per clock.
//
// Build option: define FIR_SAT_EN for round-half-up plus saturation on the
// output (o_sat flags clipping); otherwise the output is a plain truncating
// slice with two's-complement wrap and o_sat is tied low.
//
// Handshake: no backpressure. i_valid qualifies i_data on the same edge; an
// accepted sample (i_valid=1, i_clear=0) produces exactly one single-cycle
// o_valid pulse on the next cycle, and o_data/o_sat hold between pulses.
//
// Ports:
//   clk         in   rising-edge clock
//   rstn        in   synchronous active-low reset (clears banks, chain, counter)
//   i_valid     in   sample strobe; the chain advances only when high
//   i_data      in   DWIDTH  signed input sample
//   i_clear     in   synchronous flush of partial sums and warm-up counter
//   cfg_we      in   write cfg_coeff into shadow[cfg_addr]
//   cfg_addr    in   AW      tap index, 0 = newest sample; >= NTAPS ignored
//   cfg_coeff   in   CWIDTH  signed Q1.(CWIDTH-1) coefficient
//   cfg_commit  in   copy the whole shadow bank into the active bank
//   o_valid     out  output strobe
//   o_data      out  DWIDTH  signed filtered sample
//   o_sat       out  o_data was clipped (FIR_SAT_EN builds only)
//   o_primed    out  NTAPS-1 samples accepted since reset/clear
module fir_systolic
  import fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int NTAPS  = 8,
  parameter int AW     = clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid,
  input  logic signed [DWIDTH-1:0] i_data,
  input  logic                     i_clear,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic signed [CWIDTH-1:0] cfg_coeff,
  input  logic                     cfg_commit,
  output logic                     o_valid,
  output logic signed [DWIDTH-1:0] o_data,
  output logic                     o_sat,
  output logic                     o_primed
);

  localparam int            P       = prod_width(DWIDTH, CWIDTH);
  localparam int            A       = P + AW;
  localparam logic [AW-1:0] CNT_MAX = AW'(NTAPS - 1);

  logic signed [CWIDTH-1:0] shadow [NTAPS];
  logic signed [CWIDTH-1:0] active [NTAPS];
  logic [NTAPS:0][A-1:0]    acc;
  logic signed [A-1:0]      y;
  logic [AW-1:0]            cnt;
  logic                     accept;

  // A clear in the same cycle as a sample drops the sample.
  assign accept = i_valid & ~i_clear;

  // Coefficient banks. Both updates use the pre-edge shadow contents, so a
  // write and a commit in the same cycle commit the old shadow value and the
  // new write waits for the next commit. Samples accepted on the commit edge
  // still see the old active bank.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (cfg_we && (cfg_addr == AW'(k))) begin
          shadow[k] <= cfg_coeff;
        end
        if (cfg_commit) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  // Tap chain: acc[k] <= acc[k+1] + x*act[k], the oldest tap starts from 0.
  // Tap 0's register is the full-precision output register y. It is not
  // flushed by i_clear so o_data holds across a clear; the next output after
  // a clear still only sees new samples because acc[1..] are flushed.
  assign acc[NTAPS] = '0;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_ttap #(
      .DWIDTH (DWIDTH),
      .CWIDTH (CWIDTH),
      .AWIDTH (A)
    ) u_tap (
      .clk    (clk),
      .rstn   (rstn),
      .en     (accept),
      .clr    ((k == 0) ? 1'b0 : i_clear),
      .x      (i_data),
      .coeff  (active[k]),
      .acc_in (acc[k+1]),
      .acc_q  (acc[k])
    );
  end

  assign y = acc[0];

`ifdef FIR_SAT_EN
  localparam logic signed [A-1:0] RND    = A'(rnd_const(CWIDTH));
  localparam logic signed [A-1:0] SAT_HI = A'(sat_max(DWIDTH));
  localparam logic signed [A-1:0] SAT_LO = A'(sat_min(DWIDTH));

  logic signed [A-1:0] y_rnd;
  logic signed [A-1:0] y_scl;

  // Round half-up, then rescale from Q1.(CWIDTH-1) products to samples.
  // The guard bits make the rounding add overflow-free.
  assign y_rnd = y + RND;
  assign y_scl = y_rnd >>> (CWIDTH - 1);

  always_comb begin
    o_sat  = 1'b0;
    o_data = DWIDTH'(y_scl);
    if (y_scl > SAT_HI) begin
      o_data = DWIDTH'(SAT_HI);
      o_sat  = 1'b1;
    end else if (y_scl < SAT_LO) begin
      o_data = DWIDTH'(SAT_LO);
      o_sat  = 1'b1;
    end
  end
`else
  // Plain slice of bits [CWIDTH-1 +: DWIDTH]; out-of-range values wrap.
  assign o_data = DWIDTH'(y >>> (CWIDTH - 1));
  assign o_sat  = 1'b0;
`endif

  // Output strobe and saturating warm-up counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      cnt     <= '0;
    end else begin
      o_valid <= accept;
      if (i_clear) begin
        cnt <= '0;
      end else if (accept && (cnt != CNT_MAX)) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  assign o_primed = (cnt == CNT_MAX);

endmodule

// File: tb/tb_fir_systolic.sv
// tb_fir_systolic -- directed, table-driven bench for fir_systolic
// (DWIDTH=16, CWIDTH=16, NTAPS=8). Expected values are hand-computed; the
// saturation/rounding expectations follow FIR_SAT_EN when it is defined.
module tb_fir_systolic;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 8;
  localparam int AW = 3;

`ifdef FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 i_valid;
  logic signed [DW-1:0] i_data;
  logic                 i_clear;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_coeff;
  logic                 cfg_commit;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;
  logic                 o_sat;
  logic                 o_primed;

  always #5 clk = ~clk;

  fir_systolic #(
    .DWIDTH (DW),
    .CWIDTH (CW),
    .NTAPS  (NT),
    .AW     (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_clear    (i_clear),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_coeff  (cfg_coeff),
    .cfg_commit (cfg_commit),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_sat      (o_sat),
    .o_primed   (o_primed)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic vld;
    int   din;
    logic clr;
    logic exp_vld;
    int   exp_data;
    logic exp_primed;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    i_valid    = 1'b0;
    i_data     = '0;
    i_clear    = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_coeff  = '0;
    cfg_commit = 1'b0;
  endtask

  // Inputs are applied 1 time unit after an edge; tick moves to 1 unit after
  // the next edge, where outputs are sampled, and returns inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic sample(input logic v, input int d, input logic c);
    i_valid = v;
    i_data  = DW'(d);
    i_clear = c;
    tick();
  endtask

  task automatic cfg(input int addr, input int c, input logic we, input logic commit);
    cfg_we     = we;
    cfg_addr   = AW'(addr);
    cfg_coeff  = CW'(c);
    cfg_commit = commit;
    tick();
  endtask

  task automatic load_all(input int c);
    for (int k = 0; k < NT; k++) cfg(k, c, 1'b1, 1'b0);
    cfg(0, 0, 1'b0, 1'b1);
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int d, input logic p);
    chk({tag, ".o_valid"}, o_valid, v);
    chk({tag, ".o_data"}, o_data, d);
    chk({tag, ".o_primed"}, o_primed, p);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    set_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 0, 1'b0);
    chk("reset.o_sat", o_sat, 0);
    rstn = 1'b1;

    // Impulse: coeffs (k+1)*2048, input 16384 -> outputs (k+1)*1024.
    for (int k = 0; k < NT; k++) cfg(k, (k + 1) * 2048, 1'b1, 1'b0);
    cfg(0, 0, 1'b0, 1'b1);
    vecs.push_back('{1'b1, 16384, 1'b0, 1'b1, 1024, 1'b0});
    for (int i = 1; i < NT; i++)
      vecs.push_back('{1'b1, 0, 1'b0, 1'b1, (i + 1) * 1024, (i >= NT - 2)});
    vecs.push_back('{1'b1, 0, 1'b0, 1'b1, 0, 1'b1});
    vecs.push_back('{1'b0, 777, 1'b0, 1'b0, 0, 1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      sample(vecs[i].vld, vecs[i].din, vecs[i].clr);
      chk_out($sformatf("imp[%0d]", i), vecs[i].exp_vld, vecs[i].exp_data,
              vecs[i].exp_primed);
    end

    // Clear with valid: sample dropped, then DC ramps from new samples only.
    load_all(32'h1000);
    sample(1'b1, 999, 1'b1);
    chk_out("clear", 1'b0, 0, 1'b0);
    for (int n = 0; n < 9; n++) begin
      sample(1'b1, 1000, 1'b0);
      chk_out($sformatf("dc[%0d]", n), 1'b1, ((n < 8) ? (n + 1) : 8) * 125, (n >= 6));
    end

    // Stall: 1/3 valid duty, idle-cycle data must be ignored.
    sample(1'b1, 5000, 1'b1);
    for (int n = 0; n < NT; n++) begin
      sample(1'b1, 1000, 1'b0);
      chk_out($sformatf("stall[%0d]", n), 1'b1, (n + 1) * 125, (n >= 6));
      for (int g = 0; g < 2; g++) begin
        sample(1'b0, 12345, 1'b0);
        chk_out($sformatf("stall_gap[%0d.%0d]", n, g), 1'b0, (n + 1) * 125, (n >= 6));
      end
    end

    // Commit race: shadow[0]=0x2000, then write 0x4000 + commit together.
    cfg(0, 32'h2000, 1'b1, 1'b0);
    cfg(0, 32'h4000, 1'b1, 1'b1);
    sample(1'b1, 0, 1'b1);
    sample(1'b1, 8192, 1'b0);
    chk("race.old_tap0", o_data, 2048);
    sample(1'b1, 0, 1'b0);
    chk("race.tap1", o_data, 1024);
    sample(1'b1, 0, 1'b1);
    // Sample on the commit edge still sees the old bank.
    cfg_commit = 1'b1;
    i_valid    = 1'b1;
    i_data     = 16'sd8192;
    tick();
    chk("race.commit_edge", o_data, 2048);
    sample(1'b1, 0, 1'b1);
    sample(1'b1, 8192, 1'b0);
    chk("race.new_tap0", o_data, 4096);

    // Rounding: only tap0 = 0.5; +/-3 -> +/-1.5.
    for (int k = 0; k < NT; k++) cfg(k, 0, 1'b1, 1'b0);
    cfg(0, 32'h4000, 1'b1, 1'b0);
    cfg(0, 0, 1'b0, 1'b1);
    sample(1'b1, 0, 1'b1);
    sample(1'b1, 3, 1'b0);
    chk("round.pos", o_data, SAT ? 2 : 1);
    sample(1'b1, -3, 1'b0);
    chk("round.neg", o_data, SAT ? -1 : -2);
    chk("round.o_sat", o_sat, 0);

    // Saturation: all coeffs 0x7FFF.
    load_all(32'h7FFF);
    sample(1'b1, 0, 1'b1);
    sample(1'b1, 32767, 1'b0);
    chk("sat.pos1.data", o_data, 32766);
    chk("sat.pos1.o_sat", o_sat, 0);
    sample(1'b1, 32767, 1'b0);
    chk("sat.pos2.data", o_data, SAT ? 32767 : -4);
    chk("sat.pos2.o_sat", o_sat, SAT ? 1 : 0);
    sample(1'b1, 0, 1'b1);
    sample(1'b1, -32768, 1'b0);
    chk("sat.neg1.data", o_data, -32767);
    sample(1'b1, -32768, 1'b0);
    chk("sat.neg2.data", o_data, SAT ? -32768 : 2);
    chk("sat.neg2.o_sat", o_sat, SAT ? 1 : 0);
    sample(1'b0, 0, 1'b0);
    chk("sat.hold.o_sat", o_sat, SAT ? 1 : 0);

    // Reset mid-stream discards everything, coefficients included.
    load_all(32'h1000);
    for (int n = 0; n < 7; n++) sample(1'b1, 1000, 1'b0);
    chk("pre_rst.o_primed", o_primed, 1);
    rstn    = 1'b0;
    i_valid = 1'b1;
    i_data  = 16'sd1000;
    tick();
    chk_out("mid_rst", 1'b0, 0, 1'b0);
    chk("mid_rst.o_sat", o_sat, 0);
    rstn = 1'b1;
    sample(1'b1, 1000, 1'b0);
    chk_out("post_rst", 1'b1, 0, 1'b0);
    cfg(0, 0, 1'b0, 1'b1);
    sample(1'b1, 1000, 1'b0);
    chk_out("post_rst_commit", 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
